// File: rtl/aha_code_sram_pkg.sv
// Shared definitions for the Cortex-M3 code-region SRAM controller:
// AHB-Lite encodings, the controller FSM state type and the byte-merge helper.
package aha_code_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

    // ST_RWAIT is only reachable when the read wait state is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RDATA = 2'd2,
        ST_RWAIT = 2'd3
    } state_t;

    // Replace the bytes of base selected by mask with the bytes of ovr.
    function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                                input logic [31:0] ovr,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = base;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                r[8*i +: 8] = ovr[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aha_code_sram_bytemask.sv
// Byte-lane enables of an AHB transfer from HSIZE and the low address bits.
// Word and larger transfers always enable all four lanes.
module aha_code_sram_bytemask
    import aha_code_sram_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask
);

    // Decode size/offset into one, two or four active lanes.
    always_comb begin
        mask = 4'hF;
        if (hsize == HSIZE_BYTE) begin
            mask = 4'b0001 << addr_lo;
        end else if (hsize == HSIZE_HALF) begin
            mask = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
    end

endmodule

// File: rtl/aha_ahb_code_sram_ctrl.sv
// AHB-Lite slave for the Cortex-M3 code-region SRAM with a one-entry posted
// write buffer. Reads always own the SRAM port in their address phase; the
// buffered write drains in any cycle without a read address phase and is
// forwarded into read data when the word addresses match.
// Optional build macro AHA_CODE_SRAM_RD_WAIT_EN: SRAM with registered output,
// every read gets one wait state (RDATA -> RWAIT).
module aha_ahb_code_sram_ctrl
    import aha_code_sram_pkg::*;
#(
    parameter int AW = 17
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic [1:0]    HRESP,
    output logic [31:0]   HRDATA,
    output logic          SRAM_CEn,
    output logic [3:0]    SRAM_WEn,
    output logic [AW-3:0] SRAM_ADDR,
    output logic [31:0]   SRAM_WDATA,
    input  logic [31:0]   SRAM_RDATA
);

    state_t        state_q, state_d;
    logic [AW-3:0] rd_addr_q, rd_addr_d;
    logic [AW-3:0] buf_addr_q, buf_addr_d;
    logic [3:0]    buf_mask_q, buf_mask_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic          buf_valid_q, buf_valid_d;

    logic          accept, acc_wr, acc_rd;
    logic          wdata_ph, commit, commit_blk, fwd_hit;
    logic [31:0]   commit_data;
    logic [3:0]    addr_mask;
    logic          unused_bits;

    assign unused_bits = &{1'b0, HADDR[31:AW], HADDR[1:0] & 2'b00, HTRANS[0]};

    aha_code_sram_bytemask u_bytemask (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .mask    (addr_mask)
    );

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign acc_wr   = accept & HWRITE;
    assign acc_rd   = accept & ~HWRITE;
    assign wdata_ph = (state_q == ST_WDATA);
    assign fwd_hit  = buf_valid_q & (buf_addr_q == rd_addr_q);

`ifdef AHA_CODE_SRAM_RD_WAIT_EN
    assign commit_blk = (state_q == ST_RWAIT);
`else
    assign commit_blk = 1'b0;
`endif

    // A held entry drains whenever no read claims the port. A write whose data
    // is arriving right now is pushed straight through only when a new write
    // address phase is about to reuse the buffer address/mask registers.
    assign commit      = ~commit_blk & (buf_valid_q ? ~acc_rd : (wdata_ph & acc_wr));
    assign commit_data = wdata_ph ? HWDATA : buf_data_q;

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: follow the transfer accepted this cycle; reads stall once when built with the wait state.
    always_comb begin
        state_d = ST_IDLE;
        if (acc_wr) begin
            state_d = ST_WDATA;
        end else if (acc_rd) begin
            state_d = ST_RDATA;
        end
`ifdef AHA_CODE_SRAM_RD_WAIT_EN
        if (state_q == ST_RDATA) begin
            state_d = ST_RWAIT;
        end
`endif
    end

    // Write buffer and read address registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_addr_q   <= '0;
            buf_addr_q  <= '0;
            buf_mask_q  <= '0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            buf_addr_q  <= buf_addr_d;
            buf_mask_q  <= buf_mask_d;
            buf_data_q  <= buf_data_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // Load address/mask on write address phases, data on write data phases, drop valid on drain.
    always_comb begin
        rd_addr_d   = rd_addr_q;
        buf_addr_d  = buf_addr_q;
        buf_mask_d  = buf_mask_q;
        buf_data_d  = buf_data_q;
        buf_valid_d = buf_valid_q;
        if (acc_rd) begin
            rd_addr_d = HADDR[AW-1:2];
        end
        if (acc_wr) begin
            buf_addr_d = HADDR[AW-1:2];
            buf_mask_d = addr_mask;
        end
        if (wdata_ph) begin
            buf_data_d  = HWDATA;
            buf_valid_d = ~acc_wr;
        end else if (commit) begin
            buf_valid_d = 1'b0;
        end
    end

`ifdef AHA_CODE_SRAM_RD_WAIT_EN
    logic [3:0]  fwd_mask_q, fwd_mask_d;
    logic [31:0] fwd_data_q, fwd_data_d;

    // Forwarding snapshot: the buffer may drain during RDATA, but the SRAM output seen in RWAIT predates that drain.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Capture the buffer contents relevant to the outstanding read during RDATA.
    always_comb begin
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        if (state_q == ST_RDATA) begin
            fwd_mask_d = fwd_hit ? buf_mask_q : 4'h0;
            fwd_data_d = buf_data_q;
        end
    end
`endif

    // Outputs: bus response, read data merge and SRAM port arbitration (read wins).
    always_comb begin
        HRESP      = HRESP_OKAY;
        HRDATA     = 32'h0;
        SRAM_CEn   = 1'b1;
        SRAM_WEn   = 4'hF;
        SRAM_ADDR  = '0;
        SRAM_WDATA = 32'h0;
`ifdef AHA_CODE_SRAM_RD_WAIT_EN
        HREADYOUT = (state_q != ST_RDATA);
        if (state_q == ST_RWAIT) begin
            HRDATA = merge_bytes(SRAM_RDATA, fwd_data_q, fwd_mask_q);
        end
`else
        HREADYOUT = 1'b1;
        if (state_q == ST_RDATA) begin
            HRDATA = merge_bytes(SRAM_RDATA, buf_data_q, fwd_hit ? buf_mask_q : 4'h0);
        end
`endif
        if (acc_rd) begin
            SRAM_CEn  = 1'b0;
            SRAM_ADDR = HADDR[AW-1:2];
        end else if (commit) begin
            SRAM_CEn   = 1'b0;
            SRAM_WEn   = ~buf_mask_q;
            SRAM_ADDR  = buf_addr_q;
            SRAM_WDATA = commit_data;
        end
    end

endmodule

// File: tb/tb_aha_ahb_code_sram_ctrl.sv
// Directed bench for aha_ahb_code_sram_ctrl with a behavioural SRAM, a
// reference memory and a read-data scoreboard queue.
// Build with AHA_CODE_SRAM_RD_WAIT_EN to exercise the read wait-state variant.
module tb_aha_ahb_code_sram_ctrl;

    localparam int AW    = 17;
    localparam int WORDS = 1 << (AW - 2);

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic          HREADY;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HADDR;
    logic [31:0]   HWDATA;
    logic          HREADYOUT;
    logic [1:0]    HRESP;
    logic [31:0]   HRDATA;
    logic          SRAM_CEn;
    logic [3:0]    SRAM_WEn;
    logic [AW-3:0] SRAM_ADDR;
    logic [31:0]   SRAM_WDATA;
    logic [31:0]   SRAM_RDATA;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    aha_ahb_code_sram_ctrl #(.AW(AW)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HREADY     (HREADY),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HADDR      (HADDR),
        .HWDATA     (HWDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .SRAM_CEn   (SRAM_CEn),
        .SRAM_WEn   (SRAM_WEn),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WDATA (SRAM_WDATA),
        .SRAM_RDATA (SRAM_RDATA)
    );

    // Behavioural single-port SRAM (optionally with an output register).
    logic [31:0] mem [0:WORDS-1];
    logic [31:0] rd_s1 = 32'h0;
    logic [31:0] rd_s2 = 32'h0;
    logic        clr   = 1'b1;

    always @(posedge HCLK) begin
        if (clr) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
        end else if (!SRAM_CEn) begin
            if (SRAM_WEn == 4'hF) begin
                rd_s1 <= mem[SRAM_ADDR];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (!SRAM_WEn[b]) mem[SRAM_ADDR][8*b +: 8] <= SRAM_WDATA[8*b +: 8];
            end
        end
        rd_s2 <= rd_s1;
    end

`ifdef AHA_CODE_SRAM_RD_WAIT_EN
    assign SRAM_RDATA = rd_s2;
    localparam int EXP_WAITS = 1;
`else
    assign SRAM_RDATA = rd_s1;
    localparam int EXP_WAITS = 0;
`endif

    // Reference memory and scoreboard.
    logic [31:0] ref_mem [0:WORDS-1];
    logic [31:0] exp_q [$];
    logic        rd_pending  = 1'b0;
    logic [31:0] next_hwdata = 32'h0;
    int          checks      = 0;
    int          failures    = 0;
    int          waits_last  = 0;
    int          commit_cnt  = 0;

    logic          obs_cen;
    logic [3:0]    obs_wen;
    logic [AW-3:0] obs_addr;
    logic [31:0]   obs_wdata;
    logic          obs_commit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        logic [3:0] m;
        if (size == 3'd0)      m = 4'b0001 << addr[1:0];
        else if (size == 3'd1) m = addr[1] ? 4'b1100 : 4'b0011;
        else                   m = 4'b1111;
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[addr[AW-1:2]][8*b +: 8] = data[8*b +: 8];
    endtask

    // One bus cycle: kind 0 idle, 1 write, 2 read. Completes the previous data phase.
    task automatic cycle(input int kind, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
        @(negedge HCLK);
        HWDATA = next_hwdata;
        HSEL   = (kind != 0);
        HTRANS = (kind != 0) ? 2'b10 : 2'b00;
        HWRITE = (kind == 1);
        HSIZE  = size;
        HADDR  = addr;
        #1;
        waits_last = 0;
        while (HREADYOUT !== 1'b1 && waits_last < 8) begin
            waits_last++;
            @(negedge HCLK);
            #1;
        end
        if (HREADYOUT !== 1'b1) check("ready_timeout", {31'h0, HREADYOUT}, 32'h1);
        obs_cen    = SRAM_CEn;
        obs_wen    = SRAM_WEn;
        obs_addr   = SRAM_ADDR;
        obs_wdata  = SRAM_WDATA;
        obs_commit = (SRAM_CEn == 1'b0) && (SRAM_WEn != 4'hF);
        if (obs_commit) commit_cnt++;
        if (rd_pending) check("rdata", HRDATA, exp_q.pop_front());
        else            check("rdata_idle", HRDATA, 32'h0);
        rd_pending = (kind == 2);
        if (kind == 2) exp_q.push_back(ref_mem[addr[AW-1:2]]);
        if (kind == 1) begin
            ref_write(addr, size, data);
            next_hwdata = data;
        end else begin
            next_hwdata = 32'h0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hreadyout"}, {31'h0, HREADYOUT}, 32'h1);
        check({tag, "_hresp"},     {30'h0, HRESP},     32'h0);
        check({tag, "_hrdata"},    HRDATA,             32'h0);
        check({tag, "_cen"},       {31'h0, SRAM_CEn},  32'h1);
        check({tag, "_wen"},       {28'h0, SRAM_WEn},  32'hF);
        check({tag, "_addr"},      {17'h0, SRAM_ADDR}, 32'h0);
        check({tag, "_wdata"},     SRAM_WDATA,         32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stream_commits;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'd2; HWRITE = 1'b0;
        HADDR = 32'h0; HWDATA = 32'h0;
        repeat (2) @(posedge HCLK);
        clr = 1'b0;
        @(negedge HCLK);
        #1;
        check_reset_vals("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Word write then immediate read of the same address.
        cycle(1, 3'd2, 32'h100, 32'hDEADBEEF);
        cycle(2, 3'd2, 32'h100, 32'h0);
        cycle(0, 3'd2, 32'h0, 32'h0);
        check("read_wait_states", waits_last, EXP_WAITS);
`ifndef AHA_CODE_SRAM_RD_WAIT_EN
        check("wr_rd_sram_not_yet", mem[15'h40], 32'h0);
        check("wr_rd_commit_addr", {17'h0, obs_addr}, 32'h40);
        check("wr_rd_commit_wen", {28'h0, obs_wen}, 32'h0);
`else
        check("rwait_no_commit", {31'h0, obs_commit}, 32'h0);
`endif
        cycle(0, 3'd2, 32'h0, 32'h0);
        check("wr_rd_sram_after", mem[15'h40], 32'hDEADBEEF);

        // Byte merge through the forwarding path, then a halfword.
        cycle(1, 3'd2, 32'h200, 32'h11223344);
        cycle(0, 3'd2, 32'h0, 32'h0);
        cycle(0, 3'd2, 32'h0, 32'h0);
        cycle(1, 3'd0, 32'h202, 32'h00AA0000);
        cycle(2, 3'd2, 32'h200, 32'h0);
        cycle(0, 3'd2, 32'h0, 32'h0);
`ifndef AHA_CODE_SRAM_RD_WAIT_EN
        check("byte_commit_wen", {28'h0, obs_wen}, 32'hB);
        check("byte_commit_cen", {31'h0, obs_cen}, 32'h0);
`endif
        cycle(0, 3'd2, 32'h0, 32'h0);
        check("byte_sram_after", mem[15'h80], 32'h11AA3344);
        cycle(1, 3'd1, 32'h206, 32'hBEEF0000);
        cycle(2, 3'd2, 32'h204, 32'h0);
        cycle(0, 3'd2, 32'h0, 32'h0);
        cycle(0, 3'd2, 32'h0, 32'h0);
        check("half_sram_after", mem[15'h81], 32'hBEEF0000);

        // Four back-to-back word writes.
        for (int i = 0; i < 4; i++) begin
            cycle(1, 3'd2, 32'(4 * i), 32'hA0000000 + 32'(i));
`ifndef AHA_CODE_SRAM_RD_WAIT_EN
            check("stream_commit_flag", {31'h0, obs_commit}, (i == 0) ? 32'h0 : 32'h1);
            if (i > 0) begin
                check("stream_commit_addr", {17'h0, obs_addr}, 32'(i - 1));
                check("stream_commit_data", obs_wdata, 32'hA0000000 + 32'(i - 1));
            end
`endif
        end
        cycle(0, 3'd2, 32'h0, 32'h0);
`ifndef AHA_CODE_SRAM_RD_WAIT_EN
        check("stream_last_held", {31'h0, obs_commit}, 32'h0);
`endif
        cycle(0, 3'd2, 32'h0, 32'h0);
`ifndef AHA_CODE_SRAM_RD_WAIT_EN
        check("stream_last_commit", {17'h0, obs_addr}, 32'h3);
`endif
        cycle(0, 3'd2, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            check("stream_final", mem[i], 32'hA0000000 + 32'(i));

        // Write followed by a stream of eight reads of the same word.
        cycle(1, 3'd2, 32'h10, 32'h0BADF00D);
        cycle(0, 3'd2, 32'h0, 32'h0);
        cycle(0, 3'd2, 32'h0, 32'h0);
        cycle(1, 3'd2, 32'h10, 32'h5A5A0001);
        stream_commits = commit_cnt;
        for (int i = 0; i < 8; i++) cycle(2, 3'd2, 32'h10, 32'h0);
`ifndef AHA_CODE_SRAM_RD_WAIT_EN
        check("rdstream_no_commit", commit_cnt - stream_commits, 32'h0);
`endif
        cycle(0, 3'd2, 32'h0, 32'h0);
`ifndef AHA_CODE_SRAM_RD_WAIT_EN
        check("rdstream_sram_held", mem[15'h4], 32'h0BADF00D);
        check("rdstream_commit_addr", {17'h0, obs_addr}, 32'h4);
        check("rdstream_commit_flag", {31'h0, obs_commit}, 32'h1);
`endif
        cycle(0, 3'd2, 32'h0, 32'h0);
        check("rdstream_sram_after", mem[15'h4], 32'h5A5A0001);

        // Reset while a write sits in the buffer.
        cycle(1, 3'd2, 32'h300, 32'hCAFE0000);
        cycle(0, 3'd2, 32'h0, 32'h0);
        cycle(0, 3'd2, 32'h0, 32'h0);
        cycle(1, 3'd2, 32'h300, 32'h12345678);
        cycle(0, 3'd2, 32'h0, 32'h0);
        HRESETn = 1'b0;
        #1;
        check_reset_vals("midwr_reset");
        ref_mem[15'hC0] = 32'hCAFE0000;
        @(negedge HCLK);
        HRESETn = 1'b1;
        cycle(2, 3'd2, 32'h300, 32'h0);
        cycle(0, 3'd2, 32'h0, 32'h0);
        cycle(0, 3'd2, 32'h0, 32'h0);
        check("reset_discard_sram", mem[15'hC0], 32'hCAFE0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
